game_countdown_timer: RTL and testbench

- Responder side of the start/timerEnd handshake driven by btn_start_button.
- Level `start` high launches a fixed-length countdown. When the count expires the block raises `timerEnd` and holds it until `start` drops (4-phase handshake).
- Provides the remaining time in binary and in BCD for the 7-segment display path, plus a low-time warning flag.

---
 rtl/game_countdown_timer_pkg.sv | 20 ++
 rtl/game_countdown_timer_if.sv | 34 +++
 rtl/game_countdown_timer_tick_prescaler.sv | 49 ++++
 rtl/game_countdown_timer.sv | 139 +++++++++++++
 tb/tb_game_countdown_timer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/game_countdown_timer_pkg.sv
// Shared definitions for the game countdown timer.
// Contents: FSM state encoding, second/BCD widths, and the binary-to-BCD helper
// used to build the reset/reload digits of the countdown length.
package game_countdown_timer_pkg;

   localparam int SECS_W = 7;
   localparam int BCD_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Returns {tens, ones}; valid for inputs 0..99.
   function automatic logic [2*BCD_W-1:0] bin_to_bcd(input logic [SECS_W-1:0] bin);
      return {BCD_W'(bin / 7'd10), BCD_W'(bin % 7'd10)};
   endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// Start/timerEnd handshake plus countdown status bundle.
// master : the start-button side (drives start, observes the rest)
// slave  : the countdown timer (observes start, drives status)
//   start     - level, high requests/holds a game
//   timerEnd  - level, high while the countdown has expired
//   running   - high while counting
//   warn      - high while counting and time is low
//   tick      - one-cycle pulse per elapsed second
//   secs_left - remaining seconds, binary
//   secs_tens - remaining seconds, BCD tens digit
//   secs_ones - remaining seconds, BCD ones digit
interface game_countdown_timer_if;
   import game_countdown_timer_pkg::*;

   logic              start;
   logic              timerEnd;
   logic              running;
   logic              warn;
   logic              tick;
   logic [SECS_W-1:0] secs_left;
   logic [BCD_W-1:0]  secs_tens;
   logic [BCD_W-1:0]  secs_ones;

   modport master (
      output start,
      input  timerEnd, running, warn, tick, secs_left, secs_tens, secs_ones
   );

   modport slave (
      input  start,
      output timerEnd, running, warn, tick, secs_left, secs_tens, secs_ones
   );

endinterface

// File: rtl/game_countdown_timer_tick_prescaler.sv
// Divides clk down to a one-second boundary marker.
//   clk, rst - clock and async active-high reset
//   clear    - forces the count to 0 (has priority over enable)
//   enable   - advance the count this cycle
//   wrap     - high in the enabled cycle where the count is TICK_DIV-1
module game_countdown_timer_tick_prescaler #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic wrap
);

   localparam int              CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign wrap = enable && (cnt_q == CNT_MAX);

   // Next count: clear, wrap at TICK_DIV-1, or advance when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/game_countdown_timer.sv
// Game countdown timer: responder side of the start/timerEnd 4-phase handshake.
// A held start launches a GAME_SECS countdown; on expiry timerEnd is raised
// and held until start drops. Remaining time is offered in binary and BCD.
//   clk  - system clock
//   rst  - async active-high reset
//   bus  - slave side of game_countdown_timer_if (start in, status out)
module game_countdown_timer
   import game_countdown_timer_pkg::*;
#(
   parameter int TICK_DIV  = 100_000_000,
   parameter int GAME_SECS = 30,
   parameter int WARN_SECS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   game_countdown_timer_if.slave bus
);

   localparam logic [SECS_W-1:0]    RELOAD_SECS = SECS_W'(GAME_SECS);
   localparam logic [2*BCD_W-1:0]   RELOAD_BCD  = bin_to_bcd(RELOAD_SECS);
   localparam logic [SECS_W-1:0]    WARN_LIM    = SECS_W'(WARN_SECS);

   state_e             state_q, state_d;
   logic [SECS_W-1:0]  secs_q, secs_d;
   logic [BCD_W-1:0]   tens_q, tens_d;
   logic [BCD_W-1:0]   ones_q, ones_d;
   logic               tick_q, tick_d;
   logic               running_q, running_d;
   logic               timer_end_q, timer_end_d;
   logic               warn_q, warn_d;
   logic               wrap_s;
   logic               decr_s;
   logic               pre_clear_s;
   logic               pre_en_s;

   // The prescaler only advances in RUN and is zeroed whenever IDLE is next,
   // so the first RUN cycle always starts from 0.
   assign pre_en_s    = (state_q == ST_RUN);
   assign pre_clear_s = (state_d == ST_IDLE);

   game_countdown_timer_tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clear  (pre_clear_s),
      .enable (pre_en_s),
      .wrap   (wrap_s)
   );

   // A second elapses only if the game is not being aborted in the same cycle.
   assign decr_s = (state_q == ST_RUN) && bus.start && wrap_s && (secs_q != '0);

   // FSM next state; abort (start low) takes priority over the final tick.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_RUN;
            else           state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (!bus.start)                                   state_d = ST_IDLE;
            else if (wrap_s && (secs_q == SECS_W'(1)))        state_d = ST_DONE;
            else                                              state_d = ST_RUN;
         end
         ST_DONE: begin
            if (!bus.start) state_d = ST_IDLE;
            else            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Binary and BCD second counters; BCD ones borrow from tens at 0.
   always_comb begin
      secs_d = secs_q;
      tens_d = tens_q;
      ones_d = ones_q;
      if (state_d == ST_IDLE) begin
         secs_d = RELOAD_SECS;
         tens_d = RELOAD_BCD[2*BCD_W-1:BCD_W];
         ones_d = RELOAD_BCD[BCD_W-1:0];
      end else if (decr_s) begin
         secs_d = secs_q - SECS_W'(1);
         if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
         end else begin
            ones_d = ones_q - 4'd1;
            tens_d = tens_q;
         end
      end else begin
         secs_d = secs_q;
         tens_d = tens_q;
         ones_d = ones_q;
      end
   end

   // Status outputs derived from next-state values so they register in step.
   always_comb begin
      running_d   = (state_d == ST_RUN);
      timer_end_d = (state_d == ST_DONE);
      tick_d      = decr_s;
      warn_d      = (state_d == ST_RUN) && (secs_d <= WARN_LIM);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         secs_q      <= RELOAD_SECS;
         tens_q      <= RELOAD_BCD[2*BCD_W-1:BCD_W];
         ones_q      <= RELOAD_BCD[BCD_W-1:0];
         tick_q      <= 1'b0;
         running_q   <= 1'b0;
         timer_end_q <= 1'b0;
         warn_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         secs_q      <= secs_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         tick_q      <= tick_d;
         running_q   <= running_d;
         timer_end_q <= timer_end_d;
         warn_q      <= warn_d;
      end
   end

   assign bus.timerEnd  = timer_end_q;
   assign bus.running   = running_q;
   assign bus.warn      = warn_q;
   assign bus.tick      = tick_q;
   assign bus.secs_left = secs_q;
   assign bus.secs_tens = tens_q;
   assign bus.secs_ones = ones_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Self-checking bench for game_countdown_timer. Two instances:
//   A: TICK_DIV=4, GAME_SECS=3,  WARN_SECS=1
//   B: TICK_DIV=2, GAME_SECS=12, WARN_SECS=5 (BCD borrow path)
// Each DUT is compared every cycle against a model that tracks only the game
// mode and the number of clock cycles elapsed since the game began.
module tb_game_countdown_timer;

   localparam int A_DIV = 4;
   localparam int A_G   = 3;
   localparam int A_W   = 1;
   localparam int B_DIV = 2;
   localparam int B_G   = 12;
   localparam int B_W   = 5;

   typedef struct {
      int mode;    // 0 idle, 1 counting, 2 expired
      int el;      // cycles elapsed since the first counting cycle
      bit ticked;  // a whole second completed on the last edge
   } mdl_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   mdl_t ma, mb;

   game_countdown_timer_if bus_a ();
   game_countdown_timer_if bus_b ();

   game_countdown_timer #(.TICK_DIV(A_DIV), .GAME_SECS(A_G), .WARN_SECS(A_W)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a)
   );

   game_countdown_timer #(.TICK_DIV(B_DIV), .GAME_SECS(B_G), .WARN_SECS(B_W)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic mdl_t mdl_reset();
      mdl_t n;
      n.mode = 0; n.el = 0; n.ticked = 1'b0;
      return n;
   endfunction

   function automatic mdl_t mdl_next(input mdl_t m, input bit s, input int div, input int game);
      mdl_t n;
      n = m;
      n.ticked = 1'b0;
      case (m.mode)
         0: if (s) begin n.mode = 1; n.el = 0; end
         1: begin
            if (!s) n.mode = 0;
            else begin
               n.el = m.el + 1;
               n.ticked = ((n.el % div) == 0);
               if (n.el >= game * div) n.mode = 2;
            end
         end
         2: if (!s) n.mode = 0;
         default: n.mode = 0;
      endcase
      return n;
   endfunction

   function automatic int mdl_secs(input mdl_t m, input int div, input int game);
      if (m.mode == 0) return game;
      if (m.mode == 2) return 0;
      return game - (m.el / div);
   endfunction

   task automatic check_dut(input string who, input mdl_t m, input int div, input int game,
                            input int wl, input logic te, input logic rn, input logic wr,
                            input logic tk, input logic [6:0] s, input logic [3:0] t,
                            input logic [3:0] o);
      int es;
      es = mdl_secs(m, div, game);
      check_val({who, ".timerEnd"}, 32'(te), 32'(m.mode == 2));
      check_val({who, ".running"},  32'(rn), 32'(m.mode == 1));
      check_val({who, ".warn"},     32'(wr), 32'((m.mode == 1) && (es <= wl)));
      check_val({who, ".tick"},     32'(tk), 32'(m.ticked));
      check_val({who, ".secs"},     32'(s),  32'(es));
      check_val({who, ".tens"},     32'(t),  32'(es / 10));
      check_val({who, ".ones"},     32'(o),  32'(es % 10));
   endtask

   task automatic check_both();
      check_dut("A", ma, A_DIV, A_G, A_W, bus_a.timerEnd, bus_a.running, bus_a.warn,
                bus_a.tick, bus_a.secs_left, bus_a.secs_tens, bus_a.secs_ones);
      check_dut("B", mb, B_DIV, B_G, B_W, bus_b.timerEnd, bus_b.running, bus_b.warn,
                bus_b.tick, bus_b.secs_left, bus_b.secs_tens, bus_b.secs_ones);
   endtask

   // One clock edge: advance models with the sampled starts, then compare.
   task automatic step();
      @(posedge clk);
      ma = mdl_next(ma, bus_a.start, A_DIV, A_G);
      mb = mdl_next(mb, bus_b.start, B_DIV, B_G);
      #1;
      check_both();
   endtask

   // Asynchronous reset pulse between edges, checked before any clock edge.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      ma = mdl_reset();
      mb = mdl_reset();
      check_both();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      ma = mdl_reset();
      mb = mdl_reset();

      // 1: reset with no clock edge, then release and hold.
      #1 rst = 1'b1;
      #1;
      check_both();
      check_val("t1.secs", 32'(bus_a.secs_left), 32'd3);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) step();

      // 2: full countdown with start held.
      bus_a.start = 1'b1;
      repeat (13) step();
      check_val("t2.timerEnd", 32'(bus_a.timerEnd), 32'd1);

      // 3: hold in DONE, drop, restart.
      repeat (20) step();
      check_val("t3.hold_secs", 32'(bus_a.secs_left), 32'd0);
      bus_a.start = 1'b0;
      step();
      check_val("t3.reload", 32'(bus_a.secs_left), 32'd3);
      bus_a.start = 1'b1;
      repeat (13) step();
      check_val("t3.rerun_end", 32'(bus_a.timerEnd), 32'd1);

      // 4: abort mid-run, then abort on the final-wrap cycle.
      bus_a.start = 1'b0;
      step();
      bus_a.start = 1'b1;
      repeat (5) step();
      check_val("t4.mid_secs", 32'(bus_a.secs_left), 32'd2);
      bus_a.start = 1'b0;
      step();
      check_val("t4.abort_secs", 32'(bus_a.secs_left), 32'd3);
      bus_a.start = 1'b1;
      repeat (12) step();
      bus_a.start = 1'b0;
      step();
      check_val("t4.final_abort", 32'(bus_a.timerEnd), 32'd0);

      // 5: async reset mid-run, then a fresh run.
      bus_a.start = 1'b1;
      repeat (6) step();
      async_reset();
      check_val("t5.running", 32'(bus_a.running), 32'd0);
      repeat (13) step();
      check_val("t5.timerEnd", 32'(bus_a.timerEnd), 32'd1);

      // 6: two-digit countdown on instance B.
      bus_b.start = 1'b1;
      repeat (26) step();
      check_val("t6.tens", 32'(bus_b.secs_tens), 32'd0);
      check_val("t6.ones", 32'(bus_b.secs_ones), 32'd0);
      check_val("t6.timerEnd", 32'(bus_b.timerEnd), 32'd1);

      // Random start activity with occasional asynchronous resets.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 11) == 0) bus_a.start = ~bus_a.start;
         if ($urandom_range(0, 11) == 0) bus_b.start = ~bus_b.start;
         if ($urandom_range(0, 199) == 0) async_reset();
         else step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
